// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 device-side emulator: state encoding,
// protocol phase durations (in microseconds), frame length and checksum helper.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOST_LOW  = 3'd1,
    ST_RESP_WAIT = 3'd2,
    ST_RESP_LOW  = 3'd3,
    ST_RESP_HIGH = 3'd4,
    ST_BIT_LOW   = 3'd5,
    ST_BIT_HIGH  = 3'd6,
    ST_END_LOW   = 3'd7
  } dht_state_e;

  // Width of the per-state microsecond counter; it saturates at all-ones.
  localparam int US_CNT_W = 15;

  // Phase durations in microseconds.
  localparam int unsigned T_RESP_LOW_US   = 80;
  localparam int unsigned T_RESP_HIGH_US  = 80;
  localparam int unsigned T_BIT_LOW_US    = 50;
  localparam int unsigned T_BIT0_HIGH_US  = 26;
  localparam int unsigned T_BIT1_HIGH_US  = 70;
  localparam int unsigned T_END_LOW_US    = 50;

  // Time the bus gets to rise after a release before contention is judged.
  localparam int unsigned SETTLE_US       = 2;

  // Four data bytes plus checksum.
  localparam int unsigned FRAME_BITS      = 40;

  // Converts a microsecond constant to the counter width.
  function automatic logic [US_CNT_W-1:0] to_us(input int unsigned v);
    return US_CNT_W'(v);
  endfunction

  // Checksum is the plain byte sum modulo 256.
  function automatic logic [7:0] dht_checksum(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
    logic [9:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return s[7:0];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// One-microsecond strobe divider. tick is high for one cycle every
// CLK_FREQ/1e6 cycles; a synchronous reset restarts the period so the first
// tick arrives one full microsecond after the reset cycle.
module dht11_us_tick #(
  parameter int unsigned CLK_FREQ = 25000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = (CLK_FREQ / 1000000 < 1) ? 1 : CLK_FREQ / 1000000;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Strobe on the last count of each period, then wrap.
  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Period counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 device-side emulator. Waits for a host start pulse on the single-wire
// bus, then answers with the 80/80 us preamble and a 40-bit frame
// (hum_int, hum_dec, temp_int, temp_dec, checksum), MSB first. The bus is only
// ever pulled low (dht_oe=1) or released; the pull-up provides the high level.
// Optional build macro DHT11_EMU_FAULT_EN adds input fault_cksum which, when
// high at the start snapshot, inverts bit 0 of the transmitted checksum.
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 25000000,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned ABORT_US      = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
`ifdef DHT11_EMU_FAULT_EN
  input  logic       fault_cksum,
`endif
  output logic       busy,
  output logic       done,
  output logic       collision
);

  localparam logic [US_CNT_W-1:0] START_TH = to_us(START_MIN_US);
  localparam logic [US_CNT_W-1:0] ABORT_TH = to_us(ABORT_US);
  localparam logic [US_CNT_W-1:0] DELAY_TH = to_us(RESP_DELAY_US);
  localparam logic [US_CNT_W-1:0] SETTLE_TH = to_us(SETTLE_US);

  logic                sync1_q, sync2_q;
  dht_state_e          state_q, state_d;
  logic [US_CNT_W-1:0] us_cnt_q, us_cnt_d;
  logic [39:0]         shift_q, shift_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic                dht_oe_q, dht_oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                collision_q, collision_d;

  logic                tick;
  logic                tick_rst;
  logic [US_CNT_W-1:0] cur_dur;
  logic                timer_done;
  logic                released;
  logic                contention;
  logic                start_ok;
  logic                fault_bit;
  logic [7:0]          cksum;

`ifdef DHT11_EMU_FAULT_EN
  assign fault_bit = fault_cksum;
`else
  assign fault_bit = 1'b0;
`endif

  assign cksum = dht_checksum(hum_int, hum_dec, temp_int, temp_dec) ^ {7'b0, fault_bit};

  // The microsecond grid restarts on every state change so each phase lasts
  // exactly its nominal number of microseconds.
  assign tick_rst = reset || (state_d != state_q);

  dht11_us_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_us_tick (
    .clk   (clk),
    .reset (tick_rst),
    .tick  (tick)
  );

  // Nominal length of the current timed phase; untimed states return 0.
  always_comb begin
    cur_dur = '0;
    case (state_q)
      ST_RESP_WAIT: cur_dur = DELAY_TH;
      ST_RESP_LOW:  cur_dur = to_us(T_RESP_LOW_US);
      ST_RESP_HIGH: cur_dur = to_us(T_RESP_HIGH_US);
      ST_BIT_LOW:   cur_dur = to_us(T_BIT_LOW_US);
      ST_BIT_HIGH:  cur_dur = shift_q[39] ? to_us(T_BIT1_HIGH_US) : to_us(T_BIT0_HIGH_US);
      ST_END_LOW:   cur_dur = to_us(T_END_LOW_US);
      default:      cur_dur = '0;
    endcase
  end

  // Next-state, counters, frame shifter and registered-output values.
  always_comb begin
    state_d     = state_q;
    us_cnt_d    = (tick && (us_cnt_q != '1)) ? us_cnt_q + US_CNT_W'(1) : us_cnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    collision_d = collision_q;

    timer_done = tick && (us_cnt_q == cur_dur - US_CNT_W'(1));
    released   = (state_q == ST_RESP_WAIT) || (state_q == ST_RESP_HIGH) ||
                 (state_q == ST_BIT_HIGH);
    contention = released && (us_cnt_q >= SETTLE_TH) && !sync2_q;
    // Long holds are never aborted: anything past ABORT_US is accepted the
    // same way as any other hold that reached the start minimum.
    start_ok   = (us_cnt_q >= START_TH) || ((ABORT_TH >= START_TH) && (us_cnt_q > ABORT_TH));

    case (state_q)
      ST_IDLE: begin
        if (!sync2_q) state_d = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (sync2_q) begin
          if (start_ok) begin
            state_d     = ST_RESP_WAIT;
            shift_d     = {hum_int, hum_dec, temp_int, temp_dec, cksum};
            bit_cnt_d   = '0;
            collision_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP_WAIT: if (timer_done) state_d = ST_RESP_LOW;
      ST_RESP_LOW:  if (timer_done) state_d = ST_RESP_HIGH;
      ST_RESP_HIGH: if (timer_done) state_d = ST_BIT_LOW;
      ST_BIT_LOW:   if (timer_done) state_d = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (timer_done) begin
          shift_d   = {shift_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? ST_END_LOW : ST_BIT_LOW;
        end
      end
      ST_END_LOW:   if (timer_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Someone else pulling the line during our released phase ends the frame.
    if (contention) begin
      state_d     = ST_IDLE;
      collision_d = 1'b1;
    end

    if (state_d != state_q) us_cnt_d = '0;

    dht_oe_d = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) || (state_d == ST_END_LOW);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HOST_LOW);
    done_d   = (state_q == ST_END_LOW) && (state_d == ST_IDLE);
  end

  // FSM, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      us_cnt_q    <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      dht_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      sync1_q     <= dht_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      us_cnt_q    <= us_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      dht_oe_q    <= dht_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      collision_q <= collision_d;
    end
  end

  assign dht_oe    = dht_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Bench for dht11_sensor_emu. The host side of the single-wire bus is modelled
// as an open-drain driver (host_low) wired with the DUT's dht_oe onto a
// pulled-up line. Each transmitted frame is captured as a list of low/high
// run lengths and compared against a waveform list built from the byte values.
module tb_dht11_sensor_emu;

  localparam int unsigned CLK_FREQ      = 2000000;
  localparam int unsigned DIV           = CLK_FREQ / 1000000;
  localparam int unsigned START_MIN_US  = 100;
  localparam int unsigned RESP_DELAY_US = 30;
  localparam int unsigned ABORT_US      = 200;
  localparam int          N_SEG         = 83;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_low;
  logic       dht_in;
  logic       dht_oe;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic       busy, done, collision;
`ifdef DHT11_EMU_FAULT_EN
  logic       fault_cksum;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];

  // ---------------- clock / reset / bus ----------------
  always #10 clk = ~clk;

  assign dht_in = ~(dht_oe | host_low);

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog cycles_used=95000 limit=95000");
    $fatal(1, "watchdog expired");
  end

  dht11_sensor_emu #(
    .CLK_FREQ      (CLK_FREQ),
    .START_MIN_US  (START_MIN_US),
    .RESP_DELAY_US (RESP_DELAY_US),
    .ABORT_US      (ABORT_US)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dht_in    (dht_in),
    .dht_oe    (dht_oe),
    .hum_int   (hum_int),
    .hum_dec   (hum_dec),
    .temp_int  (temp_int),
    .temp_dec  (temp_dec),
`ifdef DHT11_EMU_FAULT_EN
    .fault_cksum (fault_cksum),
`endif
    .busy      (busy),
    .done      (done),
    .collision (collision)
  );

  // ---------------- reference model ----------------
  function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d,
                                              input bit flip);
    int unsigned s;
    logic [7:0]  k;
    s = a + b + c + d;
    k = 8'(s % 256);
    if (flip) k = k ^ 8'h01;
    return {a, b, c, d, k};
  endfunction

  // Expected bus waveform as seen from the DUT's driver: {pulling_low, cycles}.
  task automatic build_expected(input logic [39:0] f);
    exp_q.delete();
    exp_q.push_back({1'b1, 16'(80 * DIV)});
    exp_q.push_back({1'b0, 16'(80 * DIV)});
    for (int i = 39; i >= 0; i--) begin
      exp_q.push_back({1'b1, 16'(50 * DIV)});
      exp_q.push_back({1'b0, 16'((f[i] ? 70 : 26) * DIV)});
    end
    exp_q.push_back({1'b1, 16'(50 * DIV)});
  endtask

  // Recovers frame bits from captured high times the way a host would.
  function automatic logic [39:0] decode_obs();
    logic [39:0] f;
    f = '0;
    for (int i = 0; i < 40; i++) begin
      if (3 + 2 * i < obs_q.size())
        f[39 - i] = (obs_q[3 + 2 * i][15:0] > 16'(48 * DIV));
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
  endtask

  task automatic host_start(input int unsigned us);
    host_low = 1'b1;
    repeat (us * DIV) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Records dht_oe run lengths for one frame and counts done pulses.
  task automatic capture_frame(output int delay_cyc, output int n_done, output bit tmo);
    int   len;
    logic lv;
    obs_q.delete();
    n_done    = 0;
    tmo       = 1'b0;
    delay_cyc = 0;
    while (dht_oe !== 1'b1 && delay_cyc < 400) begin
      @(negedge clk);
      delay_cyc++;
      if (done === 1'b1) n_done++;
    end
    if (dht_oe !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    for (int s = 0; s < N_SEG; s++) begin
      lv  = dht_oe;
      len = 0;
      while (dht_oe === lv && len < 400) begin
        @(negedge clk);
        len++;
        if (done === 1'b1) n_done++;
      end
      if (len >= 400) begin
        tmo = 1'b1;
        return;
      end
      obs_q.push_back({lv, 16'(len)});
    end
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
  endtask

  // Waits until dht_oe has fallen n times (bounded); returns 1 on timeout.
  task automatic wait_oe_falls(input int n, output bit tmo);
    int   falls;
    int   cyc;
    logic prev;
    falls = 0;
    cyc   = 0;
    prev  = dht_oe;
    while (falls < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (prev === 1'b1 && dht_oe === 1'b0) falls++;
      prev = dht_oe;
    end
    tmo = (falls < n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset    = 1'b1;
    host_low = 1'b0;
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
`ifdef DHT11_EMU_FAULT_EN
    fault_cksum = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (dht_oe !== 1'b0)    begin n_err++; $display("FAIL reset_oe got=%b want=0", dht_oe); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_vec++; if (collision !== 1'b0) begin n_err++; $display("FAIL reset_collision got=%b want=0", collision); end
  endtask

  task automatic test_basic_frame();
    logic [39:0] f, dec;
    logic [16:0] got, exp;
    int          dly, nd;
    bit          tmo;
    set_bytes(8'h37, 8'h00, 8'h18, 8'h05);
    f = model_frame(8'h37, 8'h00, 8'h18, 8'h05, 1'b0);
    build_expected(f);
    host_start(150);
    repeat (4) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_on got=%b want=1", busy); end
    // Bytes changing after the start must not reach the frame.
    set_bytes(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    capture_frame(dly, nd, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL basic_timeout got=1 want=0"); end
    n_vec++;
    if (dly + 4 < int'(RESP_DELAY_US * DIV) || dly + 4 > int'(RESP_DELAY_US * DIV) + 4) begin
      n_err++; $display("FAIL basic_resp_delay got=%0d cycles want=%0d..%0d", dly + 4,
                        RESP_DELAY_US * DIV, RESP_DELAY_US * DIV + 4);
    end
    for (int i = 0; i < N_SEG; i++) begin
      exp = exp_q.pop_front();
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL basic_seg%0d got low=%b cyc=%0d want low=%b cyc=%0d",
                          i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
    dec = decode_obs();
    n_vec++; if (dec[7:0] !== 8'h54) begin n_err++; $display("FAIL basic_cksum got=%h want=54", dec[7:0]); end
    n_vec++; if (dec !== f) begin n_err++; $display("FAIL basic_decode got=%h want=%h", dec, f); end
    n_vec++; if (nd !== 1) begin n_err++; $display("FAIL basic_done_count got=%0d want=1", nd); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_off got=%b want=0", busy); end
  endtask

  task automatic test_runt();
    int    oe_seen, busy_seen, done_seen;
    int    lens[2];
    lens[0] = 60;
    lens[1] = 95;
    for (int k = 0; k < 2; k++) begin
      oe_seen = 0; busy_seen = 0; done_seen = 0;
      host_low = 1'b1;
      for (int c = 0; c < lens[k] * int'(DIV); c++) begin
        @(negedge clk);
        if (dht_oe === 1'b1) oe_seen++;
        if (busy === 1'b1) busy_seen++;
      end
      host_low = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (dht_oe === 1'b1) oe_seen++;
        if (busy === 1'b1) busy_seen++;
        if (done === 1'b1) done_seen++;
      end
      n_vec++; if (oe_seen !== 0)   begin n_err++; $display("FAIL runt%0d_oe got=%0d want=0", lens[k], oe_seen); end
      n_vec++; if (busy_seen !== 0) begin n_err++; $display("FAIL runt%0d_busy got=%0d want=0", lens[k], busy_seen); end
      n_vec++; if (done_seen !== 0) begin n_err++; $display("FAIL runt%0d_done got=%0d want=0", lens[k], done_seen); end
    end
  endtask

  task automatic test_all_ones();
    logic [39:0] f, dec;
    logic [16:0] got, exp;
    int          dly, nd;
    bit          tmo;
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    f = model_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    build_expected(f);
    host_start(150);
    capture_frame(dly, nd, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL ones_timeout got=1 want=0"); end
    for (int i = 0; i < N_SEG; i++) begin
      exp = exp_q.pop_front();
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL ones_seg%0d got low=%b cyc=%0d want low=%b cyc=%0d",
                          i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
    dec = decode_obs();
    n_vec++; if (dec[7:0] !== 8'hFC) begin n_err++; $display("FAIL ones_cksum got=%h want=fc", dec[7:0]); end
    n_vec++; if (nd !== 1) begin n_err++; $display("FAIL ones_done_count got=%0d want=1", nd); end
  endtask

  task automatic test_collision();
    bit tmo;
    int lat, done_seen, oe_seen;
    set_bytes(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    host_start(150);
    // Fall 1 opens the preamble high; fall k+2 opens the high phase of bit k.
    wait_oe_falls(12, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL coll_reach_bit10 got=timeout want=reached"); end
    done_seen = 0;
    repeat (10) @(negedge clk);
    host_low = 1'b1;
    lat = 0;
    while (collision !== 1'b1 && lat < 3 * int'(DIV)) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) done_seen++;
    end
    n_vec++; if (collision !== 1'b1) begin n_err++; $display("FAIL coll_flag got=%b want=1 within %0d cycles", collision, 3 * DIV); end
    n_vec++; if (dht_oe !== 1'b0)    begin n_err++; $display("FAIL coll_oe got=%b want=0", dht_oe); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL coll_busy got=%b want=0", busy); end
    repeat (4) @(negedge clk);
    host_low = 1'b0;
    oe_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (dht_oe === 1'b1) oe_seen++;
    end
    n_vec++; if (done_seen !== 0)    begin n_err++; $display("FAIL coll_no_done got=%0d want=0", done_seen); end
    n_vec++; if (oe_seen !== 0)      begin n_err++; $display("FAIL coll_quiet got=%0d want=0", oe_seen); end
    n_vec++; if (collision !== 1'b1) begin n_err++; $display("FAIL coll_sticky got=%b want=1", collision); end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] f, dec;
    logic [16:0] got, exp;
    logic [7:0]  b[4];
    int          dly, nd;
    bit          tmo;
    set_bytes(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    host_start(150);
    repeat (4) @(negedge clk);
    n_vec++; if (collision !== 1'b0) begin n_err++; $display("FAIL rst_coll_cleared got=%b want=0", collision); end
    wait_oe_falls(22, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL rst_reach_bit20 got=timeout want=reached"); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (dht_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid_oe got=%b want=0", dht_oe); end
    n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
    set_bytes(b[0], b[1], b[2], b[3]);
    f = model_frame(b[0], b[1], b[2], b[3], 1'b0);
    build_expected(f);
    host_start(150);
    capture_frame(dly, nd, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL rst_frame_timeout got=1 want=0"); end
    for (int i = 0; i < N_SEG; i++) begin
      exp = exp_q.pop_front();
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL rst_seg%0d got low=%b cyc=%0d want low=%b cyc=%0d",
                          i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
    dec = decode_obs();
    n_vec++; if (dec !== f) begin n_err++; $display("FAIL rst_decode got=%h want=%h", dec, f); end
    n_vec++; if (nd !== 1) begin n_err++; $display("FAIL rst_done_count got=%0d want=1", nd); end
  endtask

  task automatic test_random_near_min();
    logic [39:0] f, dec;
    logic [16:0] got, exp;
    logic [7:0]  b[4];
    int          dly, nd;
    bit          tmo;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
    set_bytes(b[0], b[1], b[2], b[3]);
    f = model_frame(b[0], b[1], b[2], b[3], 1'b0);
    build_expected(f);
    host_start(105);
    capture_frame(dly, nd, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL rand_timeout got=1 want=0"); end
    for (int i = 0; i < N_SEG; i++) begin
      exp = exp_q.pop_front();
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL rand_seg%0d got low=%b cyc=%0d want low=%b cyc=%0d",
                          i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
    dec = decode_obs();
    n_vec++; if (dec !== f) begin n_err++; $display("FAIL rand_decode got=%h want=%h", dec, f); end
    n_vec++; if (nd !== 1) begin n_err++; $display("FAIL rand_done_count got=%0d want=1", nd); end
  endtask

`ifdef DHT11_EMU_FAULT_EN
  task automatic test_fault_cksum();
    logic [39:0] dec;
    int          dly, nd;
    bit          tmo;
    set_bytes(8'h37, 8'h00, 8'h18, 8'h05);
    fault_cksum = 1'b1;
    host_start(150);
    repeat (10) @(negedge clk);
    fault_cksum = 1'b0;
    capture_frame(dly, nd, tmo);
    dec = decode_obs();
    n_vec++; if (tmo) begin n_err++; $display("FAIL fault_timeout got=1 want=0"); end
    n_vec++; if (dec[7:0] !== 8'h55) begin n_err++; $display("FAIL fault_cksum got=%h want=55", dec[7:0]); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_runt();
    test_all_ones();
    test_collision();
    test_reset_mid_frame();
    test_random_near_min();
`ifdef DHT11_EMU_FAULT_EN
    test_fault_cksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
